// File: rtl/minesweeper_pkg.sv
// Shared constants, FSM state type and marker value for the minesweeper board logic.
package minesweeper_pkg;

  localparam int ROWS   = 5;
  localparam int COLS   = 5;
  localparam int NCELLS = ROWS * COLS;
  localparam int CW     = 4;
  localparam int IDX_W  = 5;
  localparam int RC_W   = 3;

  localparam logic [CW-1:0] MINE_MARK = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/neighbor_count_if.sv
// Start/mine-map request and per-cell/full-board result bundle for neighbor_count.
interface neighbor_count_if
  import minesweeper_pkg::*;
();

  logic                   in_start;
  logic [NCELLS-1:0]      in_mines;
  logic                   out_busy;
  logic                   out_done;
  logic                   out_cell_valid;
  logic [IDX_W-1:0]       out_cell_idx;
  logic [CW-1:0]          out_cell_count;
  logic [NCELLS*CW-1:0]   out_counts;

  modport master (
    output in_start, in_mines,
    input  out_busy, out_done, out_cell_valid, out_cell_idx, out_cell_count, out_counts
  );

  modport slave (
    input  in_start, in_mines,
    output out_busy, out_done, out_cell_valid, out_cell_idx, out_cell_count, out_counts
  );

endinterface

// File: rtl/nbr_sum.sv
// Combinational adjacent-mine count for one cell; out-of-board neighbours are masked (no wrap).
module nbr_sum
  import minesweeper_pkg::*;
(
  input  logic [NCELLS-1:0] mines_i,
  input  logic [RC_W-1:0]   row_i,
  input  logic [RC_W-1:0]   col_i,
  output logic [CW-1:0]     count_o
);

  function automatic logic in_bounds(input int r, input int c);
    return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
  endfunction

  always_comb begin
    count_o = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && in_bounds(int'(row_i) + dr, int'(col_i) + dc)) begin
          count_o = count_o +
                    CW'(mines_i[IDX_W'((int'(row_i) + dr) * COLS + int'(col_i) + dc)]);
        end
      end
    end
  end

endmodule

// File: rtl/neighbor_count.sv
// Scans the mine map one cell per cycle, streaming and accumulating adjacent-mine counts.
// Optional MINE_CELL_MARK_EN: cells holding a mine report MINE_MARK instead of a count.
module neighbor_count
  import minesweeper_pkg::*;
(
  input logic             in_clka,
  input logic             in_rstn,
  neighbor_count_if.slave nc
);

  state_e               state_q, state_d;
  logic [NCELLS-1:0]    mine_q, mine_d;
  logic [RC_W-1:0]      row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     cell_idx_q, cell_idx_d;
  logic [CW-1:0]        cell_count_q, cell_count_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NCELLS*CW-1:0] counts_q, counts_d;
  logic [CW-1:0]        nbr_cnt, cell_cnt;

  nbr_sum u_nbr_sum (
    .mines_i (mine_q),
    .row_i   (row_q),
    .col_i   (col_q),
    .count_o (nbr_cnt)
  );

`ifdef MINE_CELL_MARK_EN
  assign cell_cnt = mine_q[idx_q] ? MINE_MARK : nbr_cnt;
`else
  assign cell_cnt = nbr_cnt;
`endif

  always_comb begin
    state_d      = state_q;
    mine_d       = mine_q;
    row_d        = row_q;
    col_d        = col_q;
    idx_d        = idx_q;
    cell_idx_d   = cell_idx_q;
    cell_count_d = cell_count_q;
    counts_d     = counts_q;
    valid_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (nc.in_start) begin
          mine_d   = nc.in_mines;
          counts_d = '0;
          row_d    = '0;
          col_d    = '0;
          idx_d    = '0;
          done_d   = 1'b0;
          state_d  = StScan;
        end else if (state_q == StDone) begin
          // Lags the last result by one cycle so done never overlaps a valid result.
          done_d = 1'b1;
        end
      end
      StScan: begin
        counts_d[int'(idx_q)*CW +: CW] = cell_cnt;
        cell_count_d = cell_cnt;
        cell_idx_d   = idx_q;
        valid_d      = 1'b1;
        busy_d       = 1'b1;
        idx_d        = idx_q + 1'b1;
        if (col_q == RC_W'(COLS - 1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (idx_q == IDX_W'(NCELLS - 1)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clka or negedge in_rstn) begin
    if (!in_rstn) begin
      state_q      <= StIdle;
      mine_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      cell_idx_q   <= '0;
      cell_count_q <= '0;
      counts_q     <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mine_q       <= mine_d;
      row_q        <= row_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      cell_idx_q   <= cell_idx_d;
      cell_count_q <= cell_count_d;
      counts_q     <= counts_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign nc.out_busy       = busy_q;
  assign nc.out_done       = done_q;
  assign nc.out_cell_valid = valid_q;
  assign nc.out_cell_idx   = cell_idx_q;
  assign nc.out_cell_count = cell_count_q;
  assign nc.out_counts     = counts_q;

endmodule

// File: tb/tb_neighbor_count.sv
// Scoreboard bench for neighbor_count: directed mine maps with hand-computed count boards.
module tb_neighbor_count;
  import minesweeper_pkg::*;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CW-1:0]    cnt;
  } exp_t;

  logic clk;
  logic rstn;
  neighbor_count_if nc ();

  neighbor_count dut (
    .in_clka (clk),
    .in_rstn (rstn),
    .nc      (nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k_edge = 0;
  int busy_cnt = 0;
  exp_t sb_q[$];
  logic [CW-1:0] exp_b [NCELLS];
  logic [NCELLS*CW-1:0] exp_full;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (nc.out_busy) busy_cnt++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per presented result.
  always @(negedge clk) begin
    if (nc.out_cell_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("cell_idx", nc.out_cell_idx, e.idx);
        check("cell_count", nc.out_cell_count, e.cnt);
      end
    end
  end

  task automatic do_start(input logic [NCELLS-1:0] m);
    logic [CW-1:0] e;
    exp_full = '0;
    for (int i = 0; i < NCELLS; i++) begin
      e = exp_b[i];
`ifdef MINE_CELL_MARK_EN
      if (m[i]) e = MINE_MARK;
`endif
      sb_q.push_back({IDX_W'(i), e});
      exp_full[i*CW +: CW] = e;
    end
    @(negedge clk);
    nc.in_start = 1'b1;
    nc.in_mines = m;
    @(posedge clk);
    #1;
    k_edge      = cyc;
    busy_cnt    = 0;
    nc.in_start = 1'b0;
    nc.in_mines = ~m;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (nc.out_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1'b1);
    check("done_latency", cyc - k_edge, 26);
    check("busy_cycles", busy_cnt, 25);
    check("busy_at_done", nc.out_busy, 1'b0);
    check("valid_at_done", nc.out_cell_valid, 1'b0);
    check("counts_board", nc.out_counts, exp_full);
    check("scoreboard_empty", sb_q.size(), 0);
  endtask

  task automatic wait_cell(input int idx);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (nc.out_cell_valid && nc.out_cell_idx == IDX_W'(idx)) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_cell", seen, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, nc.out_busy, 1'b0);
    check({tag, "_done"}, nc.out_done, 1'b0);
    check({tag, "_valid"}, nc.out_cell_valid, 1'b0);
    check({tag, "_idx"}, nc.out_cell_idx, '0);
    check({tag, "_count"}, nc.out_cell_count, '0);
    check({tag, "_counts"}, nc.out_counts, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    nc.in_start = 1'b0;
    nc.in_mines = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Empty board
    exp_b = '{default: 4'd0};
    do_start('0);
    wait_done();

    // Full board
    exp_b = '{4'd3, 4'd5, 4'd5, 4'd5, 4'd3,
              4'd5, 4'd8, 4'd8, 4'd8, 4'd5,
              4'd5, 4'd8, 4'd8, 4'd8, 4'd5,
              4'd5, 4'd8, 4'd8, 4'd8, 4'd5,
              4'd3, 4'd5, 4'd5, 4'd5, 4'd3};
    do_start({NCELLS{1'b1}});
    wait_done();

    // Single centre mine
    exp_b = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd1, 4'd1, 4'd1, 4'd0,
              4'd0, 4'd1, 4'd0, 4'd1, 4'd0,
              4'd0, 4'd1, 4'd1, 4'd1, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    do_start(25'd1 << 12);
    wait_done();

    // Mine at right edge of row 0: cell 5 must not see it
    exp_b = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd1, 4'd1,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    do_start(25'd1 << 4);
    wait_done();

    // Two adjacent mines at 6 and 7
    exp_b = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd0,
              4'd1, 4'd1, 4'd1, 4'd1, 4'd0,
              4'd1, 4'd2, 4'd2, 4'd1, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    do_start((25'd1 << 6) | (25'd1 << 7));
    wait_done();

    // Reset mid-scan at cell 10, then a clean rescan
    exp_b = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd1, 4'd1, 4'd1, 4'd0,
              4'd0, 4'd1, 4'd0, 4'd1, 4'd0,
              4'd0, 4'd1, 4'd1, 4'd1, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    do_start(25'd1 << 12);
    wait_cell(10);
    rstn = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    sb_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    do_start(25'd1 << 12);
    wait_done();

    // Start during scan is ignored
    exp_b = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0,
              4'd1, 4'd1, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    do_start(25'd1);
    wait_cell(7);
    nc.in_start = 1'b1;
    nc.in_mines = {NCELLS{1'b1}};
    @(posedge clk);
    #1;
    nc.in_start = 1'b0;
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neighbor_count.md
Name: neighbor_count

Overview:
- Downstream stage of the mine-placement RNG. Consumes the finished 25-bit mine map once placement completes.
- Scans the board one cell per cycle and computes each cell's adjacent-mine count (0-8).
- Streams each result and also accumulates the full count board for the display/reveal logic.

Parameters:
- ROWS, 5, board rows.
- COLS, 5, board columns; NCELLS = ROWS*COLS (25).
- CW, 4, bits per cell count.

Ports:
- in_clka  input  1  clock; all state updates on posedge.
- in_rstn  input  1  reset, asynchronous, active-low.
- in_start  input  1  start pulse; driven by the RNG's out_place_done.
- in_mines  input  NCELLS  mine map; bit i = cell i, index = row*COLS+col.
- out_busy  output  1  high while scanning.
- out_done  output  1  high once the scan completes; holds until the next accepted start.
- out_cell_valid  output  1  high for one cycle per cell result.
- out_cell_idx  output  5  cell index of the current result.
- out_cell_count  output  CW  count for out_cell_idx.
- out_counts  output  NCELLS*CW  full board; cell i occupies bits [i*CW +: CW].

Behaviour:
- Reset (async, in_rstn=0): state IDLE; out_busy=0, out_done=0, out_cell_valid=0, out_cell_idx=0, out_cell_count=0, out_counts=0; internal mine_q=0, row=0, col=0.
- Reset mid-scan: everything returns to reset values immediately; no partial results are retained.
- FSM states: IDLE, SCAN, DONE.
- IDLE, or DONE, with in_start=1 at a posedge:
  - mine_q <= in_mines; out_counts cleared; row/col <= 0; out_done <= 0; go to SCAN.
- SCAN, each cycle for the current cell (row, col):
  - Sum mine_q over the 8 neighbours that lie in bounds. No wrap across row or column edges.
  - Register the sum into out_counts[idx], out_cell_count and out_cell_idx; assert out_cell_valid.
  - Advance col; on col=COLS-1, set col=0 and row+1.
  - After idx=NCELLS-1, go to DONE.
- DONE: out_done=1, out_busy=0, out_cell_valid=0. out_counts holds stable until the next start.
- Latency: start sampled at edge k → cell results valid after edges k+1 .. k+25 → out_done high after edge k+26.
- out_busy=1 exactly during the 25 result cycles.
- in_start during SCAN is ignored, and mine_q is not re-sampled. in_mines may change freely after the start edge.
- Arithmetic: maximum count is 8, so 4 bits never overflow. Index tracking uses row/col counters, not division or modulo.
- Cell index ordering: 0 .. NCELLS-1, row-major.

Optional Feature:
- Macro: MINE_CELL_MARK_EN.
- Defined: a cell that itself holds a mine reports count 4'hF, on both out_cell_count and out_counts.
- Undefined: every cell reports its neighbour count, regardless of its own content.

Decomposition:
- Shared package minesweeper_pkg holds:
  - ROWS, COLS, NCELLS, CW, IDX_W=5;
  - the FSM state enum (IDLE/SCAN/DONE);
  - the MINE_MARK constant 4'hF.
- One sub-module is natural: nbr_sum, a combinational block with inputs (mine map, row, col) and output count. It carries the edge masking and is reusable by the reveal/flood logic.

Test Plan:
- in_mines=0, start → 25 valid cycles, all counts 0; out_done after edge k+26; out_counts=0.
- in_mines=all 1s (feature off) → corners 0,4,20,24 = 3; non-corner edge cells = 5; interior cells 6-8, 11-13, 16-18 = 8. With MINE_CELL_MARK_EN → all cells 4'hF.
- Single mine at idx 12 → cells 6,7,8,11,13,16,17,18 = 1; all others 0, including idx 12 itself (feature off).
- Mine at idx 4 only → cells 3,8,9 = 1; cell 5 = 0 (no wrap).
- Assert in_rstn=0 at cell 10 → all outputs 0 asynchronously. Restart → full correct 25-cell scan.
- Start with mine at idx 0, then pulse start at cell 7 with in_mines=all 1s → pulse ignored; results reflect the mine at idx 0 only (cells 1,5,6 = 1); out_done at edge k+26.
